// File: rtl/refill_port_arbiter.sv
// Shares one AXI4 read master between the instr- and data-cache refill engines.
// Round-robin grant, one INCR burst per cache line, beats steered to the owner.

// Per-requester return path: ack pulse, forwarded refill words, done/err pulse.
module refill_return_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  grant,
  input  logic                  beat,
  input  logic                  final_beat,
  input  logic                  burst_err,
  input  logic [DATA_WIDTH-1:0] beat_data,
  output logic                  ack,
  output logic                  rvalid,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdata
);
  // Register everything handed back so the owner sees each word one cycle after the beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack    <= 1'b0;
      rvalid <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      rdata  <= '0;
    end else begin
      ack    <= grant;
      rvalid <= beat;
      done   <= beat && final_beat;
      err    <= beat && final_beat && burst_err;
      if (beat) rdata <= beat_data;
    end
  end
endmodule

module refill_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ack,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_rvalid,
  output logic                  i_done,
  output logic                  i_err,
  input  logic                  d_req,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_rvalid,
  output logic                  d_done,
  output logic                  d_err,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [7:0]            m_arlen,
  output logic [2:0]            m_arsize,
  output logic [1:0]            m_arburst,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rlast,
  input  logic                  m_rvalid,
  output logic                  m_rready
);
  localparam int LINE_BYTES = LINE_WORDS * DATA_WIDTH / 8;
  localparam int CNT_W      = $clog2(LINE_WORDS);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t           state, state_nxt;
  logic             owner;       // 0 = instr, 1 = data
  logic             last_grant;  // 0 = instr, 1 = data
  logic [CNT_W-1:0] beat_cnt;
  logic             err_acc;

  logic             grant_go, grant_sel;
  logic             beat_fire, beat_final, beat_err;
  logic [1:0]       lane_grant, lane_beat;
  logic [1:0]       lane_ack, lane_rvalid, lane_done, lane_err;
  logic [1:0][DATA_WIDTH-1:0] lane_rdata;

  assign m_arlen   = 8'(LINE_WORDS - 1);
  assign m_arsize  = 3'($clog2(DATA_WIDTH / 8));
  assign m_arburst = 2'b01;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state: one address phase, then stay in DATA until the final beat.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_req || d_req)          state_nxt = S_ADDR;
      S_ADDR:  if (m_arvalid && m_arready)  state_nxt = S_DATA;
      S_DATA:  if (beat_fire && beat_final) state_nxt = S_IDLE;
      default:                              state_nxt = S_IDLE;
    endcase
  end

  // Decode: arbitration winner, beat acceptance and per-lane steering.
  always_comb begin
    m_rready   = (state == S_DATA);
    grant_go   = (state == S_IDLE) && (i_req || d_req);
    // Data wins when alone, or on a tie when instr had the previous grant.
    grant_sel  = d_req && (!i_req || !last_grant);
    beat_fire  = (state == S_DATA) && m_rvalid;
    beat_final = (beat_cnt == CNT_W'(LINE_WORDS - 1));
    // A response error or an rlast that disagrees with our own count taints the line.
    beat_err   = (m_rresp != 2'b00) || (m_rlast != beat_final);
    lane_grant = grant_go  ? (grant_sel ? 2'b10 : 2'b01) : 2'b00;
    lane_beat  = beat_fire ? (owner     ? 2'b10 : 2'b01) : 2'b00;
  end

  // AR channel, ownership and burst bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_arvalid  <= 1'b0;
      m_araddr   <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      beat_cnt   <= '0;
      err_acc    <= 1'b0;
    end else begin
      if (grant_go) begin
        m_arvalid  <= 1'b1;
        m_araddr   <= (grant_sel ? d_addr : i_addr) & LINE_MASK;
        owner      <= grant_sel;
        last_grant <= grant_sel;
      end else if (state == S_ADDR && m_arready) begin
        m_arvalid  <= 1'b0;
      end
      if (beat_fire) begin
        if (beat_final) begin
          beat_cnt <= '0;
          err_acc  <= 1'b0;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
          err_acc  <= err_acc | beat_err;
        end
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_lane
    refill_return_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk        (clk),
      .rst        (rst),
      .grant      (lane_grant[g]),
      .beat       (lane_beat[g]),
      .final_beat (beat_final),
      .burst_err  (err_acc | beat_err),
      .beat_data  (m_rdata),
      .ack        (lane_ack[g]),
      .rvalid     (lane_rvalid[g]),
      .done       (lane_done[g]),
      .err        (lane_err[g]),
      .rdata      (lane_rdata[g])
    );
  end

  assign i_ack    = lane_ack[0];
  assign i_rvalid = lane_rvalid[0];
  assign i_done   = lane_done[0];
  assign i_err    = lane_err[0];
  assign i_rdata  = lane_rdata[0];
  assign d_ack    = lane_ack[1];
  assign d_rvalid = lane_rvalid[1];
  assign d_done   = lane_done[1];
  assign d_err    = lane_err[1];
  assign d_rdata  = lane_rdata[1];
endmodule

// File: tb/tb_refill_port_arbiter.sv
// Bench for refill_port_arbiter: directed rounds, an AXI read slave whose memory
// word at byte address A is A>>2, and a transaction scoreboard checked every cycle.
module tb_refill_port_arbiter;
  logic        clk = 1'b0, rst;
  logic        i_req, d_req, i_ack, d_ack, i_rvalid, d_rvalid, i_done, d_done, i_err, d_err;
  logic [31:0] i_addr, d_addr, i_rdata, d_rdata, m_araddr, m_rdata;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst, m_rresp;
  logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;

  refill_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_rvalid(i_rvalid),
    .i_done(i_done), .i_err(i_err),
    .d_req(d_req), .d_addr(d_addr), .d_ack(d_ack), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
    .d_done(d_done), .d_err(d_err),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s t=%0t", nm, $time);
  endtask

  // Expected transactions, in the order the arbitration rules dictate.
  typedef struct packed {
    logic        own;   // 0 instr, 1 data
    logic [31:0] base;  // line-aligned address
    logic        err;
  } exp_t;
  exp_t exp_q[$];
  bit   m_last;         // model's record of the previous grant, 1 = data

  // Scoreboard: ack pops a transaction, returned words must be base/4 + n in order.
  exp_t cur;
  bit   cur_v = 1'b0;
  int   wc;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      chk("rst_ctl", {i_ack, i_rvalid, i_done, i_err, d_ack, d_rvalid, d_done, d_err,
                      m_arvalid, m_rready}, 0);
      chk("rst_data", {i_rdata, d_rdata}, 0);
      cur_v = 1'b0;
    end else begin
      if (i_ack || d_ack) begin
        chk("ack_single", {i_ack && d_ack, cur_v}, 0);
        if (exp_q.size() == 0) fail("ack_unexpected");
        else begin
          cur = exp_q.pop_front();
          cur_v = 1'b1;
          wc = 0;
          chk("ack_owner", d_ack, cur.own);
          chk("ar_addr", m_araddr, cur.base);
          chk("ar_fields", {m_arvalid, m_arlen, m_arsize, m_arburst}, {1'b1, 8'd3, 3'd2, 2'd1});
        end
      end
      if (i_rvalid || d_rvalid || i_done || d_done) begin
        if (!cur_v) fail("ret_unexpected");
        else begin
          chk("ret_owner", {d_rvalid, i_rvalid}, cur.own ? 2'b10 : 2'b01);
          chk("ret_data", cur.own ? d_rdata : i_rdata, (cur.base >> 2) + wc);
          wc++;
          chk("ret_done", {(cur.own ? d_done : i_done), (cur.own ? i_done : d_done)},
              {wc == 4, 1'b0});
          if (wc == 4) begin
            chk("ret_err", cur.own ? d_err : i_err, cur.err);
            cur_v = 1'b0;
          end
        end
      end
    end
  end

  // AXI slave: wait for AR, hold arready low dly cycles, then 4 back-to-back beats.
  // Returns on the cycle the final word (and done) is visible.
  task automatic serve(input int dly, input int eb, input int la);
    int t;
    logic [31:0] a;
    t = 0;
    while (!m_arvalid && t < 20) begin @(negedge clk); t++; end
    if (!m_arvalid) begin fail("ar_timeout"); return; end
    a = m_araddr;
    for (int k = 0; k < dly; k++) begin
      @(negedge clk);
      chk("ar_hold", {m_arvalid, m_araddr}, {1'b1, a});
    end
    m_arready = 1'b1;
    @(negedge clk);
    m_arready = 1'b0;
    chk("ar_drop", {m_arvalid, m_rready}, 2'b01);
    for (int k = 0; k < 4; k++) begin
      m_rvalid = 1'b1;
      m_rdata  = (a >> 2) + k;
      m_rresp  = (k == eb) ? 2'b10 : 2'b00;
      m_rlast  = (k == la);
      @(negedge clk);
    end
    m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00;
  endtask

  // Raise requests, predict grant order from the round-robin rule, serve each burst.
  task automatic arb_round(input bit ri, input bit rd, input logic [31:0] ai, input logic [31:0] ad,
                           input int dly, input int eb, input int la, output bit first);
    bit pi, pd, w, got;
    int t;
    pi = ri; pd = rd; got = 1'b0; first = 1'b0;
    i_addr = ai; d_addr = ad; i_req = ri; d_req = rd;
    while (pi || pd) begin
      if (pi && pd) w = ~m_last;
      else          w = pd;
      if (!got) begin first = w; got = 1'b1; end
      m_last = w;
      exp_q.push_back('{w, (w ? ad : ai) & ~32'hF, (eb >= 0) || (la != 3)});
      t = 0;
      do begin @(negedge clk); t++; end while (!(i_ack || d_ack) && t < 20);
      chk("ack_latency", t, 1);
      chk("ack_vec", {d_ack, i_ack}, w ? 2'b10 : 2'b01);
      if (w) begin d_req = 1'b0; pd = 1'b0; end
      else   begin i_req = 1'b0; pi = 1'b0; end
      serve(dly, eb, la);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_last = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    bit f;
    rst = 1'b1; i_req = 0; d_req = 0; i_addr = 0; d_addr = 0;
    m_arready = 0; m_rdata = 0; m_rresp = 0; m_rlast = 0; m_rvalid = 0;
    m_last = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_consts", {m_arlen, m_arsize, m_arburst, m_arvalid}, {8'd3, 3'd2, 2'd1, 1'b0});

    // 1: single instr refill, hand-computed words
    i_addr = 32'h1234; i_req = 1'b1; m_last = 1'b0;
    exp_q.push_back('{1'b0, 32'h1230, 1'b0});
    @(negedge clk);
    chk("t1_ack", {d_ack, i_ack, m_arvalid}, 3'b011);
    chk("t1_araddr", m_araddr, 32'h1230);
    i_req = 1'b0; m_arready = 1'b1;
    @(negedge clk);
    m_arready = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) begin
        chk("t1_rdata", i_rdata, 32'h48B + k);
        chk("t1_flags", {i_rvalid, i_done, i_err, d_rvalid, d_done}, (k == 4) ? 5'b11000 : 5'b10000);
      end
      m_rvalid = (k < 4);
      m_rdata  = 32'h48C + k;
      m_rlast  = (k == 3);
      @(negedge clk);
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;

    // 2: simultaneous after reset -> instr then data; instr alone; simultaneous -> data first
    do_reset();
    arb_round(1, 1, 32'h0000_4404, 32'h0000_8818, 0, -1, 3, f);
    chk("t2_first_instr", f, 1'b0);
    arb_round(1, 0, 32'h0000_5500, 32'h0, 0, -1, 3, f);
    arb_round(1, 1, 32'h0000_6628, 32'h0000_9930, 0, -1, 3, f);
    chk("t2_first_data", f, 1'b1);

    // 3: AR stalled 10 cycles
    arb_round(0, 1, 32'h0, 32'hA000_0044, 10, -1, 3, f);

    // 4: SLVERR on beat 2, then a clean refill
    arb_round(0, 1, 32'h0, 32'h0000_C008, 0, 1, 3, f);
    chk("t4_err", {d_done, d_err}, 2'b11);
    arb_round(0, 1, 32'h0, 32'h0000_C010, 0, -1, 3, f);
    chk("t4_clean", {d_done, d_err}, 2'b10);

    // rlast early -> error
    arb_round(1, 0, 32'h0000_D000, 32'h0, 0, -1, 2, f);
    chk("rlast_err", {i_done, i_err}, 2'b11);

    // 5: reset during beat 2
    i_addr = 32'h2008; i_req = 1'b1; m_last = 1'b0;
    exp_q.push_back('{1'b0, 32'h2000, 1'b0});
    @(negedge clk);
    i_req = 1'b0; m_arready = 1'b1;
    @(negedge clk);
    m_arready = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'h800;
    @(negedge clk);
    chk("t5_beat0", {i_rvalid, i_rdata}, {1'b1, 32'h800});
    m_rdata = 32'h801; rst = 1'b1;
    #1;
    chk("t5_rst_ctl", {i_ack, i_rvalid, i_done, i_err, d_ack, d_rvalid, d_done, d_err,
                       m_arvalid, m_rready}, 0);
    chk("t5_rst_data", {i_rdata, d_rdata, m_araddr}, 0);
    @(negedge clk);
    rst = 1'b0; m_rvalid = 1'b0; m_last = 1'b1;
    arb_round(1, 0, 32'h0000_3010, 32'h0, 0, -1, 3, f);
    chk("t5_recover", {i_done, i_err}, 2'b10);

    // 6: d_req raised in the i_done cycle -> data AR one cycle later
    arb_round(1, 0, 32'h0000_7004, 32'h0, 0, -1, 3, f);
    chk("t6_done", i_done, 1'b1);
    arb_round(0, 1, 32'h0, 32'h0000_E03C, 0, -1, 3, f);

    // R beats outside DATA are ignored
    m_rvalid = 1'b1; m_rdata = 32'hDEAD; m_rlast = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_rready", {m_rready, i_rvalid, d_rvalid}, 3'b000);
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
